// File: rtl/mem_cache_pkg.sv
// Shared types and constants for the direct-mapped write-through cache.
package mem_cache_pkg;

  localparam int          INDEX_BITS_DEF = 4;
  localparam int          CNT_BITS_DEF   = 16;
  localparam logic [15:0] CNT_MAX        = 16'hFFFF;

  // Word-addressed lines: the tag is what remains of the 30-bit word address.
  function automatic int tag_bits(input int index_bits);
    return 30 - index_bits;
  endfunction

  localparam int TAG_BITS_DEF = tag_bits(INDEX_BITS_DEF);

  typedef enum logic [1:0] {
    IDLE,
    MEM_RD,
    MEM_WR,
    RESP
  } state_t;

endpackage

// File: rtl/mem_cache_store.sv
// Line storage: valid/tag/data arrays, combinational lookup, one synchronous write port.
module cache_store
  import mem_cache_pkg::*;
#(
  parameter int INDEX_BITS = INDEX_BITS_DEF,
  parameter int TAG_BITS   = TAG_BITS_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [INDEX_BITS-1:0] index,
  input  logic [TAG_BITS-1:0]   tag,
  input  logic                  wr_en,
  input  logic [31:0]           wr_data,
  output logic                  hit,
  output logic [31:0]           rd_data
);

  localparam int LINES = 2 ** INDEX_BITS;

  logic [LINES-1:0]    valid;
  logic [TAG_BITS-1:0] tags [LINES];
  logic [31:0]         data [LINES];

  always_ff @(posedge clk) begin
    if (rst) valid <= '0;
    else if (wr_en) valid[index] <= 1'b1;
  end

  // NOTE: tag/data arrays have no reset; valid bits alone gate them, so they map to plain RAM.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tags[index] <= tag;
      data[index] <= wr_data;
    end
  end

  assign hit     = valid[index] && (tags[index] == tag);
  assign rd_data = data[index];

endmodule

// File: rtl/mem_cache.sv
// Direct-mapped, write-through, no-write-allocate cache with saturating hit/miss counters.
module mem_cache
  import mem_cache_pkg::*;
#(
  parameter int INDEX_BITS = INDEX_BITS_DEF,
  parameter int CNT_BITS   = CNT_BITS_DEF   // at most 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [31:0]         cpu_adr,
  input  logic [31:0]         cpu_wdata,
  input  logic                cpu_read,
  input  logic                cpu_write,
  output logic [31:0]         cpu_rdata,
  output logic                cpu_ready,
  output logic [31:0]         mem_adr,
  output logic [31:0]         mem_wdata,
  output logic                mem_read,
  output logic                mem_write,
  input  logic [31:0]         mem_rdata,
  input  logic                mem_ack,
  output logic [CNT_BITS-1:0] hit_cnt,
  output logic [CNT_BITS-1:0] miss_cnt
);

  localparam int                  TAG_BITS = tag_bits(INDEX_BITS);
  localparam logic [CNT_BITS-1:0] SAT      = CNT_MAX[CNT_BITS-1:0];

  state_t                state;
  logic [INDEX_BITS-1:0] index;
  logic [TAG_BITS-1:0]   tag;
  logic                  hit;
  logic [31:0]           line_data;
  logic                  store_we;
  logic [31:0]           store_data;
  logic                  unused_adr_bits;

  assign index           = cpu_adr[INDEX_BITS+1:2];
  assign tag             = cpu_adr[31:INDEX_BITS+2];
  assign unused_adr_bits = ^cpu_adr[1:0];

  // Strobes decode the state register directly so they drop on the edge leaving the state.
  assign mem_read  = (state == MEM_RD);
  assign mem_write = (state == MEM_WR);
  assign mem_adr   = {cpu_adr[31:2], 2'b00};
  assign mem_wdata = cpu_wdata;

  // Fills always allocate; writes only refresh a line that already holds this tag.
  always_comb begin
    store_we   = 1'b0;
    store_data = cpu_wdata;
    if (mem_ack) begin
      if (state == MEM_RD) begin
        store_we   = 1'b1;
        store_data = mem_rdata;
      end else if (state == MEM_WR) begin
        store_we   = hit;
      end
    end
  end

  cache_store #(
    .INDEX_BITS(INDEX_BITS),
    .TAG_BITS  (TAG_BITS)
  ) u_store (
    .clk    (clk),
    .rst    (rst),
    .index  (index),
    .tag    (tag),
    .wr_en  (store_we),
    .wr_data(store_data),
    .hit    (hit),
    .rd_data(line_data)
  );

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cpu_ready <= 1'b0;
      cpu_rdata <= '0;
      hit_cnt   <= '0;
      miss_cnt  <= '0;
    end else begin
      cpu_ready <= 1'b0;
      unique case (state)
        IDLE: begin
          if (cpu_write) begin
            state <= MEM_WR;
          end else if (cpu_read) begin
            if (hit) begin
              cpu_rdata <= line_data;
              cpu_ready <= 1'b1;
              state     <= RESP;
              if (hit_cnt != SAT) hit_cnt <= hit_cnt + 1'b1;
            end else begin
              state <= MEM_RD;
              if (miss_cnt != SAT) miss_cnt <= miss_cnt + 1'b1;
            end
          end
        end
        MEM_RD: begin
          if (mem_ack) begin
            cpu_rdata <= mem_rdata;
            cpu_ready <= 1'b1;
            state     <= RESP;
          end
        end
        MEM_WR: begin
          if (mem_ack) begin
            cpu_ready <= 1'b1;
            state     <= RESP;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_cache.sv
// Directed bench for mem_cache: memory model with programmable ack delay and a read-data scoreboard.
module tb_mem_cache;

  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic [31:0]      cpu_adr, cpu_wdata, cpu_rdata;
  logic             cpu_read, cpu_write, cpu_ready;
  logic [31:0]      mem_adr, mem_wdata, mem_rdata;
  logic             mem_read, mem_write, mem_ack;
  logic [CNT_W-1:0] hit_cnt, miss_cnt;

  logic [31:0] mem_model [256];
  logic [31:0] ref_mem   [256];
  logic [31:0] exp_q [$];
  logic [31:0] last_rd;
  int          ack_delay, busy_cnt, rd_cycles, wr_cycles;
  int          passed, total;

  mem_cache #(.INDEX_BITS(4), .CNT_BITS(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .cpu_adr(cpu_adr), .cpu_wdata(cpu_wdata), .cpu_read(cpu_read), .cpu_write(cpu_write),
    .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
    .mem_adr(mem_adr), .mem_wdata(mem_wdata), .mem_read(mem_read), .mem_write(mem_write),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input int i);
    case (i)
      'h10:    return 32'hDEAD_BEEF;  // 0x40
      'h20:    return 32'hCAFE_0080;  // 0x80
      'h40:    return 32'h0BAD_0100;  // 0x100
      'h12:    return 32'h5A5A_0048;  // 0x48
      default: return 32'hA000_0000 | 32'(i);
    endcase
  endfunction

  assign mem_rdata = mem_model[mem_adr[9:2]];
  assign mem_ack   = (mem_read || mem_write) && (busy_cnt >= ack_delay);

  initial begin
    for (int i = 0; i < 256; i++) mem_model[i] = init_word(i);
    forever begin
      @(posedge clk);
      if (mem_write && mem_ack) mem_model[mem_adr[9:2]] <= mem_wdata;
    end
  end

  always @(posedge clk) begin
    busy_cnt <= (mem_read || mem_write) ? busy_cnt + 1 : 0;
    if (mem_read)  rd_cycles <= rd_cycles + 1;
    if (mem_write) wr_cycles <= wr_cycles + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, got, exp);
  endtask

  // One complete core transaction, starting and ending with the DUT idle.
  task automatic access(input string tag, input bit rd, input bit wr,
                        input logic [31:0] adr, input logic [31:0] wdata,
                        input int exp_lat, input int exp_rd, input int exp_wr);
    int lat = 0;
    bit got = 0;
    int rd0 = rd_cycles;
    int wr0 = wr_cycles;
    if (wr) begin
      ref_mem[adr[9:2]] = wdata;
      exp_q.push_back(last_rd);
    end else begin
      last_rd = ref_mem[adr[9:2]];
      exp_q.push_back(last_rd);
    end
    cpu_adr = adr; cpu_wdata = wdata; cpu_read = rd; cpu_write = wr;
    while (!got && lat < 60) begin
      @(posedge clk); @(negedge clk);
      lat++;
      if (cpu_ready) got = 1;
    end
    cpu_read = 1'b0; cpu_write = 1'b0;
    if (got) check({tag, " rdata"}, cpu_rdata, exp_q.pop_front());
    else begin
      check({tag, " timeout"}, 32'(lat), 32'(exp_lat));
      void'(exp_q.pop_front());
    end
    check({tag, " latency"}, 32'(lat), 32'(exp_lat));
    @(posedge clk); @(negedge clk);
    check({tag, " mem_read cycles"}, 32'(rd_cycles - rd0), 32'(exp_rd));
    check({tag, " mem_write cycles"}, 32'(wr_cycles - wr0), 32'(exp_wr));
  endtask

  initial begin
    passed = 0; total = 0; last_rd = '0;
    busy_cnt = 0; rd_cycles = 0; wr_cycles = 0; ack_delay = 0;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
    rst = 1'b1; cpu_adr = '0; cpu_wdata = '0; cpu_read = 1'b0; cpu_write = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset cpu_ready", {31'b0, cpu_ready}, 32'h0);
    check("reset mem strobes", {30'b0, mem_read, mem_write}, 32'h0);
    check("reset cpu_rdata", cpu_rdata, 32'h0);
    check("reset hit_cnt", 32'(hit_cnt), 32'h0);
    check("reset miss_cnt", 32'(miss_cnt), 32'h0);

    access("cold read",  1, 0, 32'h40, 32'h0, 2, 1, 0);
    check("cold miss_cnt", 32'(miss_cnt), 32'd1);
    access("repeat hit", 1, 0, 32'h40, 32'h0, 1, 0, 0);
    check("repeat hit_cnt", 32'(hit_cnt), 32'd1);
    access("conflict 80", 1, 0, 32'h80, 32'h0, 2, 1, 0);
    access("conflict 40", 1, 0, 32'h43, 32'h0, 2, 1, 0);
    check("conflict miss_cnt", 32'(miss_cnt), 32'd3);

    access("write hit",  0, 1, 32'h40, 32'h1234_5678, 2, 0, 1);
    access("read after write", 1, 0, 32'h40, 32'h0, 1, 0, 0);
    access("write miss rd+wr", 1, 1, 32'h100, 32'h7777_0100, 2, 0, 1);
    access("read no-alloc", 1, 0, 32'h100, 32'h0, 2, 1, 0);
    check("after writes hit_cnt", 32'(hit_cnt), 32'd2);
    check("after writes miss_cnt", 32'(miss_cnt), 32'd4);

    ack_delay = 5;
    access("stall read", 1, 0, 32'h48, 32'h0, 7, 6, 0);
    ack_delay = 0;

    // Abort a fill with reset on its third MEM_RD cycle.
    ack_delay = 20;
    cpu_adr = 32'h4C; cpu_read = 1'b1;
    repeat (3) begin @(posedge clk); @(negedge clk); end
    check("abort in MEM_RD", {31'b0, mem_read}, 32'h1);
    rst = 1'b1; cpu_read = 1'b0;
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    check("abort mem_read low", {31'b0, mem_read}, 32'h0);
    check("abort no ready", {31'b0, cpu_ready}, 32'h0);
    repeat (3) begin
      @(posedge clk); @(negedge clk);
      check("abort idle strobes", {30'b0, cpu_ready, mem_read}, 32'h0);
    end
    check("abort cpu_rdata", cpu_rdata, 32'h0);
    last_rd = '0;
    ack_delay = 0;
    access("post-reset miss", 1, 0, 32'h48, 32'h0, 2, 1, 0);
    check("post-reset miss_cnt", 32'(miss_cnt), 32'd1);
    check("post-reset hit_cnt", 32'(hit_cnt), 32'd0);

    // Back-to-back hits: one every two cycles, well past the counter limit.
    cpu_adr = 32'h48; cpu_read = 1'b1;
    repeat (600) @(negedge clk);
    cpu_read = 1'b0;
    repeat (3) @(negedge clk);
    check("saturated hit_cnt", 32'(hit_cnt), 32'(CNT_W == 8 ? 8'hFF : 8'h00));
    check("saturation miss_cnt", 32'(miss_cnt), 32'd1);
    check("saturation rdata", cpu_rdata, 32'h5A5A_0048);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
